// File: rtl/seq_alu.sv
// Sequential ALU: add/sub in one CALC cycle, shift-add mul and restoring div over WIDTH cycles.
// Define SEQ_ALU_REM_EN to have div return the remainder in the upper half of total.
module seq_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [1:0]           sel,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   total,
    output logic                 div_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   shreg;
    logic [2*WIDTH-1:0] acc;

    logic [2*WIDTH-1:0] mul_acc;
    logic [WIDTH:0]     trial;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_fin;
    logic               div0;
    logic               last;
    logic [2*WIDTH-1:0] result;
`ifdef SEQ_ALU_REM_EN
    logic [WIDTH-1:0]   rem_fin;
`endif

    // One step of each iterative operation, plus the value total takes on completion.
    always_comb begin
        mul_acc  = acc + (shreg[0] ? ({{WIDTH{1'b0}}, opa} << cnt) : '0);
        trial    = {acc[WIDTH-1:0], shreg[WIDTH-1]};
        diff     = trial - {1'b0, opb};
        rem_next = trial[WIDTH-1:0];
        quo_next = {shreg[WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, opb}) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {shreg[WIDTH-2:0], 1'b1};
        end
        div0    = (opb == '0);
        quo_fin = div0 ? '1 : quo_next;
`ifdef SEQ_ALU_REM_EN
        rem_fin = div0 ? opa : rem_next;
`endif
        case (op)
            OP_MUL:  last = (cnt == LAST);
            OP_DIV:  last = div0 || (cnt == LAST);
            default: last = 1'b1;
        endcase
        case (op)
            OP_ADD:  result = {{WIDTH{1'b0}}, opa} + {{WIDTH{1'b0}}, opb};
            OP_SUB:  result = {{WIDTH{1'b0}}, opa} - {{WIDTH{1'b0}}, opb};
            OP_MUL:  result = mul_acc;
`ifdef SEQ_ALU_REM_EN
            default: result = {rem_fin, quo_fin};
`else
            default: result = {{WIDTH{1'b0}}, quo_fin};
`endif
        endcase
    end

    // Datapath registers: operands and iteration state, never visible at the outputs directly.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            opa   <= a;
            opb   <= b;
            op    <= sel;
            acc   <= '0;
            shreg <= (sel == OP_MUL) ? b : a;
        end else if (state == CALC) begin
            if (op == OP_MUL) begin
                acc   <= mul_acc;
                shreg <= shreg >> 1;
            end else if (op == OP_DIV) begin
                acc   <= {{WIDTH{1'b0}}, rem_next};
                shreg <= quo_next;
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            total    <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        total    <= result;
                        div_zero <= (op == OP_DIV) && div0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu (WIDTH=4): stimulus pushes expectations, a monitor checks each done.
module tb_seq_alu;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [1:0]     sel = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] total;
    logic           div_zero;

    seq_alu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .sel      (sel),
        .busy     (busy),
        .done     (done),
        .total    (total),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] tot;
        logic           dz;
        int             cyc;
        string          name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Monitor: every done strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_total"}, 32'(total), 32'(e.tot));
                chk({e.name, "_div_zero"}, 32'(div_zero), 32'(e.dz));
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_busy_at_done"}, 32'(busy), 32'd1);
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where busy is low again.
    task automatic run_op(input string name, input logic [1:0] s, input logic [W-1:0] va,
                          input logic [W-1:0] vb, input logic [2*W-1:0] et, input logic ed,
                          input int n, input bit mid_start);
        exp_t e;
        int   k;
        e.tot  = et;
        e.dz   = ed;
        e.cyc  = cyc + 1 + n;
        e.name = name;
        q.push_back(e);
        a = va; b = vb; sel = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; sel = ~s;
        k = 0;
        while (busy && k < 40) begin
            k++;
            if (mid_start && k == 2) begin
                start = 1'b1; a = 4'd3; b = 4'd3; sel = 2'b00;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({name, "_busy_cycles"}, 32'(k), 32'(n + 1));
    endtask

    initial begin
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_total", 32'(total), 32'd0);
        chk("reset_div_zero", 32'(div_zero), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add_15_15", 2'b00, 4'd15, 4'd15, 8'h1E, 1'b0, 1, 1'b0);
        run_op("sub_3_5",   2'b01, 4'd3,  4'd5,  8'hFE, 1'b0, 1, 1'b0);
        run_op("sub_5_3",   2'b01, 4'd5,  4'd3,  8'h02, 1'b0, 1, 1'b0);
        run_op("mul_15_15", 2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 4, 1'b1);
        run_op("mul_7_6",   2'b10, 4'd7,  4'd6,  8'h2A, 1'b0, 4, 1'b0);
`ifdef SEQ_ALU_REM_EN
        run_op("div_13_4",  2'b11, 4'd13, 4'd4,  8'h13, 1'b0, 4, 1'b0);
        run_op("div_9_0",   2'b11, 4'd9,  4'd0,  8'h9F, 1'b1, 1, 1'b0);
`else
        run_op("div_13_4",  2'b11, 4'd13, 4'd4,  8'h03, 1'b0, 4, 1'b0);
        run_op("div_9_0",   2'b11, 4'd9,  4'd0,  8'h0F, 1'b1, 1, 1'b0);
`endif
        run_op("add_after_div0", 2'b00, 4'd2, 4'd3, 8'h05, 1'b0, 1, 1'b0);

        // Abort mul 7*6 with reset during its third CALC cycle.
        a = 4'd7; b = 4'd6; sel = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_total", 32'(total), 32'd0);
        chk("abort_div_zero", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("add_1_1", 2'b00, 4'd1, 4'd1, 8'h02, 1'b0, 1, 1'b0);

        repeat (6) @(negedge clk);
        chk("missing_done", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request pulse; sampled on a rising edge of clk.
REQ-005 SHALL have port a  input  WIDTH  unsigned operand A.
REQ-006 SHALL have port b  input  WIDTH  unsigned operand B.
REQ-007 SHALL have port sel  input  2  operation code: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress (CALC or DONE state).
REQ-009 SHALL have port done  output  1  one-cycle completion strobe.
REQ-010 SHALL have port total  output  2*WIDTH  result register.
REQ-011 SHALL have port div_zero  output  1  the last division had b==0.

Function
REQ-012 SHALL implement the FSM states IDLE, CALC and DONE; the reset state is IDLE.
REQ-013 SHALL accept start only in IDLE; on acceptance it latches a, b and sel and moves to CALC.
REQ-014 SHALL ignore start while in CALC or DONE; no queuing, latched operands unaffected.
REQ-015 SHALL stay in CALC for N cycles: N=1 for add, sub and div with b==0; N=WIDTH for mul and div with b!=0.
REQ-016 SHALL spend exactly one cycle in DONE after CALC, with done=1; it then returns to IDLE, with done back to 0.
REQ-017 SHALL therefore assert done N+1 cycles after the accepting edge; start high in that IDLE cycle is accepted back-to-back.
REQ-018 SHALL update total only on the edge entering DONE; total holds that value until the next completion or reset.
REQ-019 SHALL make add produce total = zero-extended a+b, with the carry landing in total[WIDTH].
REQ-020 SHALL make sub produce total = (a-b) mod 2^(2*WIDTH), i.e. two's-complement wrap over the full result width.
REQ-021 SHALL make mul compute the unsigned product with an iterative shift-add, one multiplier bit per CALC cycle, total = a*b exactly.
REQ-022 SHALL make div compute unsigned restoring division, one quotient bit per CALC cycle, MSB first; the quotient goes in total[WIDTH-1:0].
REQ-023 SHALL, for div with b==0, produce a quotient of all ones and a remainder equal to a, with div_zero=1.
REQ-024 SHALL set div_zero on every div completion (1 if b==0, else 0); non-div completions clear it.
REQ-025 SHALL use no combinational path from any input to any output.

Reset
REQ-026 SHALL, on rst_n low, at any time including mid-CALC, immediately force IDLE with busy=0, done=0, total=0, div_zero=0.
REQ-027 SHALL make an operation aborted by reset produce no done strobe and leave no partial result visible.
REQ-028 SHALL synchronise reset release externally; the block accepts start on the first edge with rst_n high.

Configuration
REQ-029 SHALL provide the macro SEQ_ALU_REM_EN, which selects whether div returns the remainder.
REQ-030 SHALL, with SEQ_ALU_REM_EN defined, make div drive total[2*WIDTH-1:WIDTH] with the remainder (equal to a when b==0).
REQ-031 SHALL, without SEQ_ALU_REM_EN, make div drive total[2*WIDTH-1:WIDTH] with 0 and remove the remainder register from the design; all other operations are unchanged.

Verification (WIDTH=4)
REQ-032 SHALL cover add 15+15: total=8'h1E, done 2 cycles after acceptance, busy high for those 2 cycles.
REQ-033 SHALL cover sub 3-5: total=8'hFE; then sub 5-3: total=8'h02; div_zero=0 throughout.
REQ-034 SHALL cover mul 15*15: total=8'hE1 with done 5 cycles after acceptance; a start pulsed mid-CALC is ignored and the result is unchanged.
REQ-035 SHALL cover div 13/4: total=8'h13 with SEQ_ALU_REM_EN, 8'h03 without; done 5 cycles after acceptance; div_zero=0.
REQ-036 SHALL cover div 9/0: total=8'h9F with SEQ_ALU_REM_EN, 8'h0F without; div_zero=1; done 2 cycles after acceptance.
REQ-037 SHALL cover rst_n pulsed low in the third CALC cycle of mul 7*6: outputs go to 0 at once, no done; then add 1+1 gives total=8'h02.
